// File: rtl/bcd2bin_n.sv
// N-digit BCD to binary converter, one digit per cycle, MSD first.
// Flags any digit above 9 and then reports a zero result.
module bcd2bin_n #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd,
    output logic                  ready,
    output logic                  done_tick,
    output logic                  err,
    output logic [BIN_W-1:0]      bin
);

    localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    function automatic int min_width(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return $clog2(p);
    endfunction

    generate
        if (N_DIGITS < 1 || BIN_W < min_width(N_DIGITS)) begin : g_param_chk
            $error("bcd2bin_n: N_DIGITS=%0d BIN_W=%0d out of range",
                   N_DIGITS, BIN_W);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        OP,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [4*N_DIGITS-1:0] sr;
    logic [BIN_W-1:0]      acc;
    logic [BIN_W-1:0]      acc_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  err_acc;
    logic                  err_nxt;
    logic [3:0]            digit;
    logic                  last;

    assign digit   = sr[4*N_DIGITS-1 -: 4];
    assign acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(digit);
    assign err_nxt = err_acc | (digit > 4'd9);
    assign last    = (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done_tick = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = OP;
            end
            OP: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done_tick = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results are committed only on the edge that enters DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
            bin     <= '0;
            err     <= 1'b0;
        end else if (state == IDLE && start) begin
            sr      <= bcd;
            acc     <= '0;
            cnt     <= CNT_W'(N_DIGITS - 1);
            err_acc <= 1'b0;
        end else if (state == OP) begin
            acc     <= acc_nxt;
            err_acc <= err_nxt;
            sr      <= sr << 4;
            if (last) begin
                bin <= err_nxt ? '0 : acc_nxt;
                err <= err_nxt;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd2bin_n.sv
// Scoreboard bench for bcd2bin_n: 4-digit and 2-digit instances.
// Expected results come from a digit-weight arithmetic model.
module tb_bcd2bin_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a;
    logic [15:0] bcd_a;
    logic        ready_a, done_a, err_a;
    logic [13:0] bin_a;
    logic        start_b;
    logic [7:0]  bcd_b;
    logic        ready_b, done_b, err_b;
    logic [6:0]  bin_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int bin;
        int err;
        int cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    bcd2bin_n #(.N_DIGITS(4), .BIN_W(14)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bcd(bcd_a),
        .ready(ready_a), .done_tick(done_a), .err(err_a), .bin(bin_a)
    );

    bcd2bin_n #(.N_DIGITS(2), .BIN_W(7)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bcd(bcd_b),
        .ready(ready_b), .done_tick(done_b), .err(err_b), .bin(bin_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Value = sum of digit * 10^position; invalid digit forces err and zero.
    function automatic exp_t model(input logic [63:0] v, input int nd,
                                   input int w, input int cap);
        exp_t   e;
        longint val;
        longint p;
        int     d;
        val = 0;
        p = 1;
        e.err = 0;
        for (int i = 0; i < nd; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) e.err = 1;
            val = val + longint'(d) * p;
            p = p * 10;
        end
        e.bin = e.err ? 0 : int'(val % (longint'(1) << w));
        e.cyc = cap + nd;
        return e;
    endfunction

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (done_a === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_spurious_done: got done_tick=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = qa.pop_front();
                check("a_bin", 64'(bin_a), 64'(e.bin));
                check("a_err", 64'(err_a), 64'(e.err));
                check("a_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (done_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_spurious_done: got done_tick=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = qb.pop_front();
                check("b_bin", 64'(bin_b), 64'(e.bin));
                check("b_err", 64'(err_b), 64'(e.err));
                check("b_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic conv_a(input logic [15:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("a_ready_wait", 64'(ready_a), 64'(1));
        bcd_a = v;
        start_a = 1'b1;
        qa.push_back(model(64'(v), 4, 14, cyc + 1));
        @(negedge clk);
        start_a = 1'b0;
        bcd_a = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() + qb.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(qa.size() + qb.size()), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        int n;
        reset = 1'b1;
        start_a = 1'b0;
        bcd_a = '0;
        start_b = 1'b0;
        bcd_b = '0;
        repeat (2) @(negedge clk);
        check("rst_ready_a", 64'(ready_a), 64'(1));
        check("rst_done_a", 64'(done_a), 64'(0));
        check("rst_err_a", 64'(err_a), 64'(0));
        check("rst_bin_a", 64'(bin_a), 64'(0));
        check("rst_ready_b", 64'(ready_b), 64'(1));
        check("rst_bin_b", 64'(bin_b), 64'(0));
        reset = 1'b0;

        conv_a(16'h0000);
        conv_a(16'h9999);
        conv_a(16'h1234);
        conv_a(16'h12A4);
        conv_a(16'h0042);
        drain();

        conv_a(16'h5678);
        bcd_a = 16'h1111;
        start_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("busy_ready", 64'(ready_a), 64'(0));
            @(negedge clk);
            start_a = 1'b0;
            bcd_a = 16'($urandom);
        end
        repeat (8) @(negedge clk);
        check("busy_back_idle", 64'(ready_a), 64'(1));
        check("busy_one_result", 64'(qa.size()), 64'(0));

        conv_a(16'h2345);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ready", 64'(ready_a), 64'(1));
        check("midrst_bin", 64'(bin_a), 64'(0));
        check("midrst_err", 64'(err_a), 64'(0));
        check("midrst_done", 64'(done_a), 64'(0));
        qa.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_bin_held", 64'(bin_a), 64'(0));
        conv_a(16'h0007);

        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < 4; j++)
                r[4*j +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0)
                r[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            conv_a(r);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        @(negedge clk);
        bcd_b = to_bcd2(0);
        start_b = 1'b1;
        qb.push_back(model(64'(bcd_b), 2, 7, cyc + 1));
        for (int v = 0; v < 100; v++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done_b !== 1'b1 && n < 20);
            if (done_b !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL b_timeout: got no done_tick expected one for value %0d", v);
            end
            if (v < 99) begin
                bcd_b = to_bcd2(v + 1);
                qb.push_back(model(64'(bcd_b), 2, 7, cyc + 2));
            end else begin
                start_b = 1'b0;
            end
        end
        drain();
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
